// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative signed/unsigned multiply and restoring divide with start/busy/done handshake
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIXUP, DONE} state_t;
  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic                 is_div, sa, sb;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  assign is_div   = op_q[1];
  assign sa       = ~op_q[0] & a_q[WIDTH-1];
  assign sb       = ~op_q[0] & b_q[WIDTH-1];
  assign a_mag    = sa ? -a_q : a_q;
  assign b_mag    = sb ? -b_q : b_q;
  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient bits}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? b_q : {WIDTH{1'b0}}};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, b_q};
  assign div_next = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    // handshake outputs are registered off the state, so they trail it by one cycle
    busy_d  = state_q == PREP || state_q == RUN || state_q == FIXUP;
    done_d  = state_q == DONE;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        a_d     = a;
        b_d     = b;
        dz_d    = 1'b0;
        state_d = PREP;
      end
      PREP: begin
        b_d     = b_mag;
        neg_p_d = sa ^ sb;
        neg_r_d = sa;
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        cnt_d   = CNT_W'(WIDTH);
        dz_d    = is_div && b_q == '0;
        state_d = (is_div && b_q == '0) ? DONE : RUN;
      end
      RUN: begin
        acc_d   = is_div ? div_next : mul_next;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? FIXUP : RUN;
      end
      FIXUP: begin
        if (is_div) begin
          lo_d = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_p_q ? -acc_q : acc_q;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed checks of mult_div_seq at WIDTH=32 and WIDTH=8
module tb_mult_div_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start8 = 1'b0;
  logic [1:0]  op = 2'b00, op8 = 2'b00;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy, done, div_zero, busy8, done8, dz8;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mult_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );
  mult_div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );
  // lat = edges after the accepting edge until done is seen; -1 if it never came
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = ~o; a = ~x; b = ~y;
    lat = -1; bc = 0;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) lat = i;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    n_chk++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
    reset = 1'b0;
  endtask
  task automatic test_signed_mult;
    int lat, bc;
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, lat, bc);
    n_chk++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_fail++; $display("FAIL smul got %h want FFFFFFFFFFFFFFF1", {hi, lo}); end
    n_chk++; if (lat !== 35) begin n_fail++; $display("FAIL smul_latency got %0d want 35", lat); end
    n_chk++; if (bc !== 34) begin n_fail++; $display("FAIL smul_busy_cycles got %0d want 34", bc); end
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL smul_done_width got %b want 0", done); end
  endtask
  task automatic test_unsigned_mult;
    int lat, bc;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_chk++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL umul_max got %h want FFFFFFFE00000001", {hi, lo}); end
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_chk++; if ({hi, lo} !== 64'h00000000_00000001) begin n_fail++; $display("FAIL smul_m1 got %h want 0000000000000001", {hi, lo}); end
  endtask
  task automatic test_div;
    int lat, bc;
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    n_chk++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL sdiv got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
    n_chk++; if (lat !== 35) begin n_fail++; $display("FAIL sdiv_latency got %0d want 35", lat); end
    do_op(2'b11, 32'h00000007, 32'h00000002, lat, bc);
    n_chk++; if ({hi, lo} !== 64'h00000001_00000003) begin n_fail++; $display("FAIL udiv got %h want 0000000100000003", {hi, lo}); end
  endtask
  task automatic test_div_zero;
    int lat, bc;
    bit seen;
    do_op(2'b01, 32'h00010000, 32'h12345678, lat, bc);
    n_chk++; if ({hi, lo} !== 64'h00001234_56780000) begin n_fail++; $display("FAIL prior_mul got %h want 0000123456780000", {hi, lo}); end
    do_op(2'b10, 32'h00000005, 32'h00000000, lat, bc);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL dz_latency got %0d want 2", lat); end
    n_chk++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_zero); end
    n_chk++; if ({hi, lo} !== 64'h00001234_56780000) begin n_fail++; $display("FAIL dz_hold got %h want 0000123456780000", {hi, lo}); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_sticky got %b want 1", div_zero); end
    @(negedge clk);
    op = 2'b11; a = 32'd7; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_chk++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b want 0", div_zero); end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(posedge clk); #1; seen = done; end
    n_chk++; if (!seen || {hi, lo} !== 64'h00000001_00000003) begin n_fail++; $display("FAIL dz_next_op got %h done=%b want 0000000100000003", {hi, lo}, seen); end
  endtask
  task automatic test_overflow;
    int lat, bc;
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    n_chk++; if ({hi, lo, div_zero} !== {64'h00000000_80000000, 1'b0}) begin n_fail++; $display("FAIL sdiv_ovf got %h dz=%b want 0000000080000000 dz=0", {hi, lo}, div_zero); end
  endtask
  task automatic test_ignored_start;
    bit seen;
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 a = 32'd7; b = 32'd7; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(posedge clk); #1; seen = done; end
    n_chk++; if (!seen || {hi, lo} !== 64'd15) begin n_fail++; $display("FAIL ignored_start got %h done=%b want 000000000000000F", {hi, lo}, seen); end
  endtask
  task automatic test_back_to_back;
    int gap;
    bit seen;
    @(negedge clk);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(posedge clk); #1; seen = done; end
    n_chk++; if (!seen || {hi, lo} !== 64'd6) begin n_fail++; $display("FAIL b2b_first got %h done=%b want 0000000000000006", {hi, lo}, seen); end
    a = 32'd4; b = 32'd5;
    gap = -1;
    for (int i = 1; i <= 100 && gap < 0; i++) begin @(posedge clk); #1; if (done) gap = i; end
    start = 1'b0;
    n_chk++; if (gap !== 36) begin n_fail++; $display("FAIL b2b_gap got %0d want 36", gap); end
    n_chk++; if ({hi, lo} !== 64'd20) begin n_fail++; $display("FAIL b2b_second got %h want 0000000000000014", {hi, lo}); end
  endtask
  task automatic test_abort;
    int lat, bc, dones;
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_chk++; if ({hi, lo, busy, done, div_zero} !== 67'h0) begin n_fail++; $display("FAIL abort_clear got %h %b%b%b want all 0", {hi, lo}, busy, done, div_zero); end
    dones = 0;
    repeat (50) begin @(posedge clk); #1; if (done) dones++; end
    n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
    do_op(2'b01, 32'd6, 32'd7, lat, bc);
    n_chk++; if ({hi, lo} !== 64'd42 || lat !== 35) begin n_fail++; $display("FAIL abort_recover got %h lat %0d want 000000000000002A lat 35", {hi, lo}, lat); end
  endtask
  task automatic test_width8;
    int lat;
    @(negedge clk);
    op8 = 2'b00; a8 = 8'hFD; b8 = 8'h05; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = -1;
    for (int i = 1; i <= 50 && lat < 0; i++) begin @(posedge clk); #1; if (done8) lat = i; end
    n_chk++; if ({hi8, lo8} !== 16'hFFF1) begin n_fail++; $display("FAIL w8_smul got %h want FFF1", {hi8, lo8}); end
    n_chk++; if (lat !== 11) begin n_fail++; $display("FAIL w8_latency got %0d want 11", lat); end
  endtask
  initial begin
    test_reset();
    test_signed_mult();
    test_unsigned_mult();
    test_div();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
